// File: rtl/regfile_writeback_pkg.sv
// Shared widths, defaults and the buffered write-back entry type for the
// register-file write-back path.
package regfile_writeback_pkg;

    localparam int unsigned REG_ADDR_W       = 5;
    localparam int unsigned DATA_W           = 32;
    localparam int unsigned DEF_FIFO_DEPTH   = 2;
    localparam int unsigned DEF_STARVE_LIMIT = 4;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] wa;
        logic [DATA_W-1:0]     wd;
    } wb_entry_t;

    // Register 0 is hardwired to zero, so writes to it are discarded.
    function automatic logic is_x0(input logic [REG_ADDR_W-1:0] addr);
        return addr == '0;
    endfunction

endpackage

// File: rtl/regfile_writeback_fifo.sv
// Count-based synchronous FIFO buffering long-latency write-back results.
// Pointers wrap naturally because DEPTH is a power of two.
module wb_fifo
    import regfile_writeback_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_FIFO_DEPTH
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  wb_entry_t push_data,
    input  logic      pop,
    output wb_entry_t head,
    output logic      full,
    output logic      empty
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    wb_entry_t         mem_q [DEPTH];
    wb_entry_t         mem_d [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              do_push;
    logic              do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign head    = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        count_d = count_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only read while count_q says valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/regfile_writeback.sv
// Arbitrates single-cycle ALU results against buffered long-latency results
// onto the register file's single registered write port, and tracks pending regs.
module regfile_writeback
    import regfile_writeback_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH   = DEF_FIFO_DEPTH,
    parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alu_valid,
    input  logic [REG_ADDR_W-1:0] alu_wa,
    input  logic [DATA_W-1:0]     alu_wd,
    output logic                  alu_stall,
    input  logic                  lu_valid,
    output logic                  lu_ready,
    input  logic [REG_ADDR_W-1:0] lu_wa,
    input  logic [DATA_W-1:0]     lu_wd,
    input  logic                  issue_valid,
    input  logic [REG_ADDR_W-1:0] issue_wa,
    output logic [31:0]           pending,
    output logic                  we,
    output logic [REG_ADDR_W-1:0] wa,
    output logic [DATA_W-1:0]     wd
);

    localparam int unsigned SW = $clog2(STARVE_LIMIT + 2);

    wb_entry_t             lu_entry;
    wb_entry_t             fifo_head;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  lu_push;
    logic                  fifo_pop;
    logic                  alu_take;

    logic [SW-1:0]         starve_q, starve_d;
    logic [31:0]           pending_q, pending_d;
    logic                  we_q, we_d;
    logic [REG_ADDR_W-1:0] wa_q, wa_d;
    logic [DATA_W-1:0]     wd_q, wd_d;

    assign lu_entry.wa = lu_wa;
    assign lu_entry.wd = lu_wd;

    wb_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (lu_push),
        .push_data (lu_entry),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Readiness uses the current count only: a same-cycle pop never frees a slot early.
    always_comb begin
        lu_ready  = !rst && !fifo_full;
        alu_stall = !rst && !fifo_empty && (starve_q == SW'(STARVE_LIMIT));
        lu_push   = lu_valid && lu_ready;
        alu_take  = alu_valid && !alu_stall;
        fifo_pop  = !rst && !alu_take && !fifo_empty;
    end

    always_comb begin
        we_d = 1'b0;
        wa_d = wa_q;
        wd_d = wd_q;
        if (alu_take) begin
            we_d = !is_x0(alu_wa);
            wa_d = alu_wa;
            wd_d = alu_wd;
        end else if (fifo_pop) begin
            we_d = !is_x0(fifo_head.wa);
            wa_d = fifo_head.wa;
            wd_d = fifo_head.wd;
        end
    end

    always_comb begin
        starve_d = starve_q;
        if (fifo_pop || fifo_empty) begin
            starve_d = '0;
        end else if (alu_take) begin
            starve_d = starve_q + SW'(1);
        end
    end

    // Clear is applied before set so an issue to the retiring register wins.
    always_comb begin
        pending_d = pending_q;
        if (fifo_pop && !is_x0(fifo_head.wa)) begin
            pending_d[fifo_head.wa] = 1'b0;
        end
        if (issue_valid && !is_x0(issue_wa)) begin
            pending_d[issue_wa] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_q  <= '0;
            pending_q <= '0;
            we_q      <= 1'b0;
            wa_q      <= '0;
            wd_q      <= '0;
        end else begin
            starve_q  <= starve_d;
            pending_q <= pending_d;
            we_q      <= we_d;
            wa_q      <= wa_d;
            wd_q      <= wd_d;
        end
    end

    assign pending = pending_q;
    assign we      = we_q;
    assign wa      = wa_q;
    assign wd      = wd_q;

endmodule

// File: tb/tb_regfile_writeback.sv
// Bench for regfile_writeback: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against a queue-based reference model.
module tb_regfile_writeback;

    localparam int unsigned DEPTH = 2;
    localparam int unsigned LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid;
    logic [4:0]  alu_wa;
    logic [31:0] alu_wd;
    logic        alu_stall;
    logic        lu_valid;
    logic        lu_ready;
    logic [4:0]  lu_wa;
    logic [31:0] lu_wd;
    logic        issue_valid;
    logic [4:0]  issue_wa;
    logic [31:0] pending;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;

    regfile_writeback #(
        .FIFO_DEPTH   (DEPTH),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .alu_valid   (alu_valid),
        .alu_wa      (alu_wa),
        .alu_wd      (alu_wd),
        .alu_stall   (alu_stall),
        .lu_valid    (lu_valid),
        .lu_ready    (lu_ready),
        .lu_wa       (lu_wa),
        .lu_wd       (lu_wd),
        .issue_valid (issue_valid),
        .issue_wa    (issue_wa),
        .pending     (pending),
        .we          (we),
        .wa          (wa),
        .wd          (wd)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the buffer is a queue, the scoreboard a bit vector.
    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_pend;
    int          m_starve;
    bit          m_we;
    logic [4:0]  m_wa;
    logic [31:0] m_wd;
    bit          m_chk_wad;
    bit          m_valid = 1'b0;

    always @(negedge clk) begin
        bit   m_ready;
        bit   m_stall;
        bit   take;
        bit   popq;
        int   sz0;
        ent_t h;
        if (m_valid) begin
            chk("we", 32'(we), 32'(m_we));
            chk("pending", pending, m_pend);
            if (m_chk_wad) begin
                chk("wa", 32'(wa), 32'(m_wa));
                chk("wd", wd, m_wd);
            end
        end
        sz0     = mq.size();
        m_ready = !rst && (sz0 < DEPTH);
        m_stall = !rst && (sz0 > 0) && (m_starve == LIMIT);
        if (m_valid) begin
            chk("lu_ready", 32'(lu_ready), 32'(m_ready));
            chk("alu_stall", 32'(alu_stall), 32'(m_stall));
        end
        if (rst) begin
            mq.delete();
            m_pend    = '0;
            m_starve  = 0;
            m_we      = 1'b0;
            m_wa      = '0;
            m_wd      = '0;
            m_chk_wad = 1'b1;
            m_valid   = 1'b1;
        end else begin
            take      = alu_valid && !m_stall;
            popq      = !take && (sz0 > 0);
            m_we      = 1'b0;
            m_chk_wad = 1'b0;
            if (take) begin
                m_we = (alu_wa != 0);
                m_wa = alu_wa;
                m_wd = alu_wd;
            end else if (popq) begin
                h    = mq.pop_front();
                m_we = (h.a != 0);
                m_wa = h.a;
                m_wd = h.d;
                if (h.a != 0) m_pend[h.a] = 1'b0;
            end
            m_chk_wad = m_we;
            if (issue_valid && issue_wa != 0) m_pend[issue_wa] = 1'b1;
            if (popq || sz0 == 0) m_starve = 0;
            else if (take) m_starve = m_starve + 1;
            if (lu_valid && m_ready) mq.push_back('{lu_wa, lu_wd});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] raddr();
        int unsigned r;
        r = $urandom_range(0, 9);
        if (r < 2) return 5'd0;
        if (r < 8) return 5'(r);
        return 5'($urandom_range(0, 31));
    endfunction

    initial begin
        bit h_alu;
        bit h_lu;
        rst = 1'b1; alu_valid = 1'b0; alu_wa = '0; alu_wd = '0;
        lu_valid = 1'b0; lu_wa = '0; lu_wd = '0; issue_valid = 1'b0; issue_wa = '0;
        tick();
        chk("rst_we", 32'(we), 32'd0);
        chk("rst_pending", pending, 32'd0);
        chk("rst_lu_ready", 32'(lu_ready), 32'd0);
        tick();
        rst = 1'b0;
        #1 chk("post_rst_lu_ready", 32'(lu_ready), 32'd1);

        // ALU only
        alu_valid = 1'b1; alu_wa = 5'd5; alu_wd = 32'hDEADBEEF;
        tick();
        alu_valid = 1'b0;
        chk("alu_we", 32'(we), 32'd1);
        chk("alu_wa", 32'(wa), 32'd5);
        chk("alu_wd", wd, 32'hDEADBEEF);
        chk("alu_pending", pending, 32'd0);

        // Scoreboard set then clear on the write-back
        issue_valid = 1'b1; issue_wa = 5'd7;
        tick();
        issue_valid = 1'b0;
        chk("sb_set", pending, 32'h80);
        lu_valid = 1'b1; lu_wa = 5'd7; lu_wd = 32'h1234;
        #1 chk("sb_lu_ready", 32'(lu_ready), 32'd1);
        tick();
        lu_valid = 1'b0;
        chk("sb_still_pending", pending, 32'h80);
        tick();
        chk("sb_we", 32'(we), 32'd1);
        chk("sb_wa", 32'(wa), 32'd7);
        chk("sb_wd", wd, 32'h1234);
        chk("sb_clear", pending, 32'd0);

        // Full FIFO backpressure while ALU is busy
        alu_valid = 1'b1; alu_wa = 5'd9; alu_wd = 32'h9999;
        lu_valid = 1'b1; lu_wa = 5'd10; lu_wd = 32'hA0;
        tick();
        lu_wa = 5'd11; lu_wd = 32'hB0;
        tick();
        lu_wa = 5'd12; lu_wd = 32'hC0;
        #1 chk("full_ready0", 32'(lu_ready), 32'd0);
        tick();
        #1 chk("full_ready1", 32'(lu_ready), 32'd0);
        tick();
        alu_valid = 1'b0;
        tick();
        chk("full_wa1", 32'(wa), 32'd10);
        chk("full_ready_popcycle", 32'(lu_ready), 32'd1);
        tick();
        lu_valid = 1'b0;
        chk("full_wa2", 32'(wa), 32'd11);
        tick();
        chk("full_we3", 32'(we), 32'd1);
        chk("full_wa3", 32'(wa), 32'd12);
        chk("full_wd3", wd, 32'hC0);

        // Starvation limit
        alu_valid = 1'b1; alu_wa = 5'd20; alu_wd = 32'h20;
        lu_valid = 1'b1; lu_wa = 5'd21; lu_wd = 32'h21;
        tick();
        lu_valid = 1'b0;
        chk("starve_wa0", 32'(wa), 32'd20);
        for (int i = 0; i < 4; i++) begin
            alu_wa = 5'(22 + i); alu_wd = 32'(22 + i);
            #1 chk("starve_nostall", 32'(alu_stall), 32'd0);
            tick();
            chk("starve_alu_wa", 32'(wa), 32'(22 + i));
        end
        alu_wa = 5'd26; alu_wd = 32'h26;
        #1 chk("starve_stall", 32'(alu_stall), 32'd1);
        tick();
        chk("starve_head_we", 32'(we), 32'd1);
        chk("starve_head_wa", 32'(wa), 32'd21);
        #1 chk("starve_released", 32'(alu_stall), 32'd0);
        tick();
        alu_valid = 1'b0;
        chk("starve_held_wa", 32'(wa), 32'd26);
        chk("starve_held_wd", wd, 32'h26);

        // x0 discard and set-wins collision
        issue_valid = 1'b1; issue_wa = 5'd3;
        tick();
        issue_valid = 1'b0;
        lu_valid = 1'b1; lu_wa = 5'd0; lu_wd = 32'hFFFF;
        tick();
        lu_wa = 5'd3; lu_wd = 32'h33;
        tick();
        lu_valid = 1'b0;
        chk("x0_we", 32'(we), 32'd0);
        issue_valid = 1'b1; issue_wa = 5'd3;
        tick();
        issue_valid = 1'b0;
        chk("coll_we", 32'(we), 32'd1);
        chk("coll_wa", 32'(wa), 32'd3);
        chk("coll_pending", pending, 32'h08);

        // Reset with buffered entries and pending bits
        issue_valid = 1'b1; issue_wa = 5'd7;
        tick();
        issue_valid = 1'b0;
        alu_valid = 1'b1; alu_wa = 5'd1; alu_wd = 32'h1;
        lu_valid = 1'b1; lu_wa = 5'd4; lu_wd = 32'h44;
        tick();
        lu_wa = 5'd6; lu_wd = 32'h66;
        tick();
        chk("prerst_pending", pending, 32'h88);
        rst = 1'b1; alu_valid = 1'b0; lu_valid = 1'b0;
        #1;
        chk("inrst_lu_ready", 32'(lu_ready), 32'd0);
        chk("inrst_alu_stall", 32'(alu_stall), 32'd0);
        tick();
        chk("midrst_we", 32'(we), 32'd0);
        chk("midrst_wa", 32'(wa), 32'd0);
        chk("midrst_wd", wd, 32'd0);
        chk("midrst_pending", pending, 32'd0);
        rst = 1'b0;
        #1 chk("midrst_lu_ready", 32'(lu_ready), 32'd1);
        tick();
        chk("midrst_no_write", 32'(we), 32'd0);

        // Randomized traffic; upstream holds stalled/refused offers
        repeat (3000) begin
            @(negedge clk);
            h_alu = alu_valid && alu_stall;
            h_lu  = lu_valid && !lu_ready;
            @(posedge clk);
            #1;
            rst = ($urandom_range(0, 249) == 0);
            if (!h_alu) begin
                alu_valid = ($urandom_range(0, 99) < 60);
                alu_wa    = raddr();
                alu_wd    = $urandom;
            end
            if (!h_lu) begin
                lu_valid = ($urandom_range(0, 99) < 50);
                lu_wa    = raddr();
                lu_wd    = $urandom;
            end
            issue_valid = ($urandom_range(0, 99) < 40);
            issue_wa    = raddr();
        end

        rst = 1'b0; alu_valid = 1'b0; lu_valid = 1'b0; issue_valid = 1'b0;
        repeat (10) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_writeback.md
REGFILE_WRITEBACK -- requirements
Module: regfile_writeback

Interface
REQ-001 Parameter: FIFO_DEPTH, default 2, number of long-latency result buffer entries (power of 2, >=2).
REQ-002 Parameter: STARVE_LIMIT, default 4, consecutive ALU-priority cycles allowed while the buffer is non-empty.
REQ-003 Port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port: rst  input  1  reset, synchronous and active-high.
REQ-005 Port: alu_valid  input  1  single-cycle result present this cycle.
REQ-006 Port: alu_wa  input  5  ALU destination register.
REQ-007 Port: alu_wd  input  32  ALU result.
REQ-008 Port: alu_stall  output  1  ALU result not accepted this cycle; upstream holds its inputs.
REQ-009 Port: lu_valid  input  1  long-latency (load/mul/div) result offered.
REQ-010 Port: lu_ready  output  1  buffer accepts the offered result this cycle.
REQ-011 Port: lu_wa  input  5  long-latency destination register.
REQ-012 Port: lu_wd  input  32  long-latency result.
REQ-013 Port: issue_valid  input  1  long-latency op issued this cycle.
REQ-014 Port: issue_wa  input  5  destination register of the issued op.
REQ-015 Port: pending  output  32  scoreboard; bit n=1 means register n awaits a long-latency write.
REQ-016 Port: we  output  1  register-file write enable, registered.
REQ-017 Port: wa  output  5  register-file write address, registered.
REQ-018 Port: wd  output  32  register-file write data, registered.

Function
REQ-019 The block SHALL drive the register file's single synchronous write port, with each accepted write appearing on we/wa/wd exactly one cycle after acceptance.
REQ-020 A transfer on the lu port SHALL occur in a cycle where lu_valid=1 and lu_ready=1; the block SHALL push {lu_wa, lu_wd} into the FIFO.
REQ-021 lu_ready SHALL equal (FIFO count < FIFO_DEPTH) and rst=0; a push is refused when the FIFO is full, even if a pop occurs that same cycle.
REQ-022 Each cycle the block SHALL select at most one write: an ALU write when alu_valid=1 and alu_stall=0; otherwise the FIFO head when the FIFO is non-empty (popped); otherwise none (next we=0).
REQ-023 starve_cnt SHALL increment on each cycle an ALU write is selected while the FIFO is non-empty, and clear on any FIFO pop or whenever the FIFO is empty.
REQ-024 alu_stall SHALL be 1 exactly when starve_cnt == STARVE_LIMIT and the FIFO is non-empty; in that cycle the FIFO head is popped and the ALU input is ignored.
REQ-025 Writes with address 0 from either source SHALL be consumed (ALU accepted, FIFO popped) but produce we=0 on the next cycle.
REQ-026 When issue_valid=1 and issue_wa!=0, pending[issue_wa] SHALL set on the next edge; bit 0 SHALL always read 0.
REQ-027 A FIFO pop to register n!=0 SHALL clear pending[n] on the next edge; ALU writes SHALL NOT affect pending.
REQ-028 When a set and a clear target the same bit in one cycle, set SHALL win.
REQ-029 An lu push and a FIFO pop in the same cycle (FIFO not full) SHALL leave the count unchanged and preserve order.
REQ-030 FIFO pointers SHALL wrap modulo FIFO_DEPTH with no loss or duplication of entries.

Reset
REQ-031 While rst=1 at a clock edge: we=0, wa=0, wd=0, pending=0, FIFO empty, starve_cnt=0; lu_ready=0 and alu_stall=0 throughout the reset cycle.
REQ-032 Reset mid-operation SHALL discard all buffered results and scoreboard bits, and SHALL leave no write outstanding after the edge.

Structure
REQ-033 A shared package SHALL hold REG_ADDR_W=5, DATA_W=32, and the default FIFO_DEPTH and STARVE_LIMIT.
REQ-034 The FIFO SHALL be a sub-module, wb_fifo (synchronous, count-based full/empty); the arbiter, starve counter and scoreboard are implemented in regfile_writeback.

Verification
REQ-035 ALU only: alu_valid=1, alu_wa=5, alu_wd=0xDEADBEEF -> next cycle we=1, wa=5, wd=0xDEADBEEF; pending unchanged.
REQ-036 Scoreboard: issue_wa=7, later lu push {7,0x1234} with alu idle -> pending[7]=1 until the write; we=1, wa=7 one cycle after the pop; pending[7]=0 the same cycle.
REQ-037 Full/backpressure: 3 lu pushes while ALU busy (FIFO_DEPTH=2) -> third push sees lu_ready=0 and is held; the writes emerge in order after ALU idles.
REQ-038 Starvation: FIFO holds 1 entry and alu_valid=1 continuously -> 4 ALU writes, then alu_stall=1 for one cycle with the FIFO head written; the held ALU write follows next.
REQ-039 x0 and collision: lu write to 0 -> popped, we=0; issue_wa=3 in the same cycle as the pop clearing reg 3 -> pending[3]=1.
REQ-040 Reset: assert rst with 2 buffered entries and pending=0x88 -> after the edge, we=0, pending=0, lu_ready=1 on the first cycle with rst=0.
